// File: rtl/mod_uart_tx.sv
// mod_uart_tx: 8N1 UART transmitter with a 16x baud-tick generator.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module mod_uart_tx #(
  parameter int DVSR    = 163,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_din,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done_tick
);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [4:0]  r_s;
  logic [2:0]  r_n;
  logic [7:0]  r_b;
  logic        r_tx, r_busy, r_done;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif
  logic        w_tick, w_accept;
  assign w_tick         = r_cnt == 16'(DVSR);
  assign w_accept       = r_state == IDLE && i_tx_start;
  assign o_tx           = r_tx;
  assign o_tx_busy      = r_busy;
  assign o_tx_done_tick = r_done;
  // The tick counter restarts on acceptance so every bit spans exactly 16*(DVSR+1) clocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_cnt  <= (w_accept || w_tick) ? '0 : r_cnt + 16'd1;
      case (r_state)
        IDLE: if (i_tx_start) begin
          r_b     <= i_din;
          r_s     <= '0;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= START;
`ifdef UART_TX_PARITY_EN
          r_par   <= ^i_din[DBIT-1:0];
`endif
        end
        START: if (w_tick) begin
          if (r_s == 5'd15) begin
            r_s     <= '0;
            r_n     <= '0;
            r_tx    <= r_b[0];
            r_state <= DATA;
          end else r_s <= r_s + 5'd1;
        end
        DATA: if (w_tick) begin
          if (r_s == 5'd15) begin
            r_s <= '0;
            r_b <= r_b >> 1;
            if (r_n == 3'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_n  <= r_n + 3'd1;
              r_tx <= r_b[1];
            end
          end else r_s <= r_s + 5'd1;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (w_tick) begin
          if (r_s == 5'd15) begin
            r_s     <= '0;
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else r_s <= r_s + 5'd1;
        end
`endif
        STOP: if (w_tick) begin
          if (r_s == 5'(SB_TICK - 1)) begin
            r_s     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else r_s <= r_s + 5'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_uart_tx.sv
// tb_mod_uart_tx: directed self-checking bench for mod_uart_tx at DVSR=3 (64 clocks per bit).
module tb_mod_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, busy, done;
  int         n_cmp = 0, n_err = 0;

  mod_uart_tx #(.DVSR(3), .DBIT(8), .SB_TICK(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_start(tx_start), .i_din(din),
    .o_tx(tx), .o_tx_busy(busy), .o_tx_done_tick(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge where tx_start was raised; checks every cycle of the frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                           input int noise_at);
    logic [SLOTS-1:0] bits;
    int bad_tx = 0, bad_st = 0, cyc = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = par;
`endif
    bits[SLOTS-1] = 1'b1;
    for (int sl = 0; sl < SLOTS; sl++)
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        tx_start = (cyc == noise_at);
        din = (cyc == noise_at) ? 8'hFF : ~d;
        if (tx !== bits[sl]) bad_tx++;
        if (busy !== 1'b1 || done !== 1'b0) bad_st++;
        cyc++;
      end
    @(negedge clk);
    chk({tag, " tx bits"}, bad_tx, 0);
    chk({tag, " busy/done in frame"}, bad_st, 0);
    chk({tag, " done at end"}, done, 1);
    chk({tag, " busy at end"}, busy, 0);
    chk({tag, " tx at end"}, tx, 1);
  endtask

  initial begin
    int bad;
    repeat (5) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle 1000 clocks", bad, 0);

    tx_start = 1'b1; din = 8'hA5;
    run_frame("A5", 8'hA5, 1'b0, -1);
    tx_start = 1'b1; din = 8'h3C;
    run_frame("3C b2b", 8'h3C, 1'b0, -1);

    @(negedge clk);
    tx_start = 1'b1; din = 8'h00;
    run_frame("00 noisy", 8'h00, 1'b0, 100);
    bad = 0;
    repeat (SLOTS * 64 + 10) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("no queued frame", bad, 0);

    tx_start = 1'b1; din = 8'hA5;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * 64 + 31) @(negedge clk);
    chk("tx mid d3 before reset", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("async reset tx", tx, 1);
    chk("async reset busy", busy, 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1) bad++;
    end
    rst_n = 1'b1;
    repeat (SLOTS * 64) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abandoned frame quiet", bad, 0);
    tx_start = 1'b1; din = 8'h55;
    run_frame("55 after reset", 8'h55, 1'b0, -1);

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    tx_start = 1'b1; din = 8'h07;
    run_frame("07 parity", 8'h07, 1'b1, -1);
    @(negedge clk);
    tx_start = 1'b1; din = 8'h03;
    run_frame("03 parity", 8'h03, 1'b0, -1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
